// File: rtl/brc_seq.sv
// rtl/brc_seq.sv - multi-cycle chunked branch comparator (optional macro: BRC_EARLY_EXIT_EN)
//
// Compares operand A (rs1) against operand B (rs2 or the immediate) one CHUNK_W
// slice per cycle, most significant slice first. The first slice that differs
// decides "less"; if no slice differs the operands are equal. The funct3 code
// captured at acceptance is decoded into the branch-taken bit.
//
// BRC_EARLY_EXIT_EN defined   : the scan stops on the first differing slice.
// BRC_EARLY_EXIT_EN undefined : the scan always covers every slice, giving a
//                               constant latency of NCHUNK cycles.
// Flag values are identical in both builds.
//
// DATA_W must be a multiple of CHUNK_W.

module brc_seq #(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_rs1_data,
  input  logic [DATA_W-1:0] i_rs2_data,
  input  logic [DATA_W-1:0] i_imm,
  input  logic              i_imm_sel,
  input  logic              i_br_un,
  input  logic [2:0]        i_funct3,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_br_less,
  output logic              o_br_equal,
  output logic              o_br_taken
);

  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NCHUNK - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;

`ifdef BRC_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  b_q;
  logic               un_q;
  logic [2:0]         f3_q;
  // found_q/less_q remember the first differing slice while the scan continues
  logic               found_q;
  logic               less_q;

  logic [CHUNK_W-1:0] a_chunks [NCHUNK];
  logic [CHUNK_W-1:0] b_chunks [NCHUNK];
  logic [CHUNK_W-1:0] a_sel;
  logic [CHUNK_W-1:0] b_sel;
  logic [CHUNK_W-1:0] a_c;
  logic [CHUNK_W-1:0] b_c;
  logic               diff_now;
  logic               lt_now;
  logic               last_chunk;
  logic               fin_less;
  logic               fin_equal;
  logic               cmp_exit;

  // Slice the latched operands into per-cycle comparison chunks
  always_comb begin
    for (int i = 0; i < NCHUNK; i++) begin
      a_chunks[i] = a_q[i*CHUNK_W +: CHUNK_W];
      b_chunks[i] = b_q[i*CHUNK_W +: CHUNK_W];
    end
  end

  generate
    if (NCHUNK == 1) begin : g_single
      assign a_sel = a_chunks[0];
      assign b_sel = b_chunks[0];
    end else begin : g_multi
      assign a_sel = a_chunks[idx];
      assign b_sel = b_chunks[idx];
    end
  endgenerate

  // Current-slice compare; flipping the sign bit maps two's complement onto unsigned order
  always_comb begin
    a_c = a_sel;
    b_c = b_sel;
    if (!un_q && (idx == IDX_TOP)) begin
      a_c[CHUNK_W-1] = ~a_sel[CHUNK_W-1];
      b_c[CHUNK_W-1] = ~b_sel[CHUNK_W-1];
    end
    diff_now   = (a_c != b_c);
    lt_now     = (a_c < b_c);
    last_chunk = (idx == IDX_ZERO);
    // A difference already recorded outranks anything in lower slices
    fin_less   = found_q ? less_q : (diff_now && lt_now);
    fin_equal  = !found_q && !diff_now;
    cmp_exit   = last_chunk || (EARLY_EXIT && !found_q && diff_now);
  end

  function automatic logic decode_taken(input logic [2:0] f3,
                                        input logic       less,
                                        input logic       equal);
    logic t;
    case (f3)
      3'b000:         t = equal;
      3'b001:         t = !equal;
      3'b100, 3'b110: t = less;
      3'b101, 3'b111: t = !less;
      default:        t = 1'b0;
    endcase
    return t;
  endfunction

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      idx        <= IDX_ZERO;
      a_q        <= '0;
      b_q        <= '0;
      un_q       <= 1'b0;
      f3_q       <= 3'b000;
      found_q    <= 1'b0;
      less_q     <= 1'b0;
      o_ready    <= 1'b1;
      o_valid    <= 1'b0;
      o_br_less  <= 1'b0;
      o_br_equal <= 1'b0;
      o_br_taken <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid && o_ready) begin
            a_q     <= i_rs1_data;
            b_q     <= i_imm_sel ? i_imm : i_rs2_data;
            un_q    <= i_br_un;
            f3_q    <= i_funct3;
            idx     <= IDX_TOP;
            found_q <= 1'b0;
            less_q  <= 1'b0;
            o_ready <= 1'b0;
            state   <= S_CMP;
          end
        end
        S_CMP: begin
          if (cmp_exit) begin
            o_br_less  <= fin_less;
            o_br_equal <= fin_equal;
            o_br_taken <= decode_taken(f3_q, fin_less, fin_equal);
            o_valid    <= 1'b1;
            state      <= S_DONE;
          end else begin
            idx <= idx - IDX_W'(1);
            if (!found_q && diff_now) begin
              found_q <= 1'b1;
              less_q  <= lt_now;
            end
          end
        end
        S_DONE: begin
          // Result is held until consumed; the return to IDLE costs one bubble
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_brc_seq.sv
// tb/tb_brc_seq.sv - directed self-checking bench for brc_seq (DATA_W=32, CHUNK_W=8)

module tb_brc_seq;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] imm;
  logic        imm_sel;
  logic        br_un;
  logic [2:0]  funct3;
  logic        o_valid;
  logic        i_ready;
  logic        br_less;
  logic        br_equal;
  logic        br_taken;

  int n_tests;
  int n_fail;
  int lat;

`ifdef BRC_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  brc_seq #(.DATA_W(32), .CHUNK_W(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_rs1_data (rs1),
    .i_rs2_data (rs2),
    .i_imm      (imm),
    .i_imm_sel  (imm_sel),
    .i_br_un    (br_un),
    .i_funct3   (funct3),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_br_less  (br_less),
    .o_br_equal (br_equal),
    .o_br_taken (br_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for o_valid; lat counts edges after the acceptance edge
  task automatic wait_valid(input string tag, output int cycles);
    cycles = 0;
    while (!o_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    chk({tag, "_valid_seen"}, 32'(o_valid), 32'd1);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic sel, input logic un, input logic [2:0] f3);
    rs1     = a;
    rs2     = b;
    imm     = im;
    imm_sel = sel;
    br_un   = un;
    funct3  = f3;
  endtask

  // One request with i_ready held high; checks latency, flags and return to IDLE
  task automatic run_req(input string tag,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic sel, input logic un, input logic [2:0] f3,
                         input logic e_less, input logic e_eq, input logic e_taken,
                         input int e_lat);
    int l;
    drive(a, b, im, sel, un, f3);
    i_ready = 1'b1;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000);
    wait_valid(tag, l);
    chk({tag, "_latency"}, 32'(l), 32'(e_lat));
    chk({tag, "_less"},    32'(br_less),  32'(e_less));
    chk({tag, "_equal"},   32'(br_equal), 32'(e_eq));
    chk({tag, "_taken"},   32'(br_taken), 32'(e_taken));
    tick();
    chk({tag, "_idle_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(o_ready), 32'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_valid", 32'(o_valid),  32'd0);
    chk("rst_ready", 32'(o_ready),  32'd1);
    chk("rst_less",  32'(br_less),  32'd0);
    chk("rst_equal", 32'(br_equal), 32'd0);
    chk("rst_taken", 32'(br_taken), 32'd0);

    // -1 < 1 signed; top slice differs
    run_req("t1_signed_blt", 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 3'b100,
            1'b1, 1'b0, 1'b1, EARLY ? 1 : 4);
    // Same operands unsigned: 0xFFFFFFFF > 1
    run_req("t2_unsigned_bltu", 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 1'b1, 3'b110,
            1'b0, 1'b0, 1'b0, EARLY ? 1 : 4);
    // Equal operands always scan every slice
    run_req("t3_beq", 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 3'b000,
            1'b0, 1'b1, 1'b1, 4);
    // Immediate path: 5 vs -5 signed; rs2 would have given less=1 if used
    run_req("t4_imm_sel", 32'h0000_0005, 32'h7FFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0, 3'b010,
            1'b0, 1'b0, 1'b0, EARLY ? 1 : 4);
    // Difference only in the lowest slice
    run_req("t_bge_low", 32'h0000_0003, 32'h0000_0007, 32'h0, 1'b0, 1'b1, 3'b101,
            1'b1, 1'b0, 1'b0, 4);
    run_req("t_bne_low", 32'h0000_0003, 32'h0000_0007, 32'h0, 1'b0, 1'b1, 3'b001,
            1'b1, 1'b0, 1'b1, 4);
    // Sign boundary: INT_MIN < INT_MAX signed, greater unsigned
    run_req("t_min_max_s", 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b0, 3'b100,
            1'b1, 1'b0, 1'b1, EARLY ? 1 : 4);
    run_req("t_min_max_u", 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, 3'b111,
            1'b0, 1'b0, 1'b1, EARLY ? 1 : 4);
    // First difference wins even though lower slices favour the other way
    run_req("t_first_diff", 32'h0100_0000, 32'h00FF_FFFF, 32'h0, 1'b0, 1'b1, 3'b110,
            1'b0, 1'b0, 1'b0, EARLY ? 1 : 4);
    // Signed compare of two negatives with difference in slice 1
    run_req("t_neg_neg", 32'hFFFF_80FF, 32'hFFFF_7FFF, 32'h0, 1'b0, 1'b0, 3'b101,
            1'b0, 1'b0, 1'b1, EARLY ? 3 : 4);

    // Backpressure: result held while i_ready=0, new request ignored
    drive(32'h0000_0003, 32'h0000_0007, 32'h0, 1'b0, 1'b1, 3'b100);
    i_ready = 1'b0;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    wait_valid("t5", lat);
    chk("t5_latency", 32'(lat), 32'd4);
    drive(32'h0000_0009, 32'h0000_0009, 32'h0, 1'b0, 1'b1, 3'b001);
    i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("t5_hold_valid", 32'(o_valid),  32'd1);
      chk("t5_hold_less",  32'(br_less),  32'd1);
      chk("t5_hold_equal", 32'(br_equal), 32'd0);
      chk("t5_hold_taken", 32'(br_taken), 32'd1);
      chk("t5_hold_ready", 32'(o_ready),  32'd0);
      tick();
    end
    chk("t5_still_valid", 32'(o_valid), 32'd1);
    i_ready = 1'b1;
    tick();
    chk("t5_bubble_valid", 32'(o_valid), 32'd0);
    chk("t5_bubble_ready", 32'(o_ready), 32'd1);
    tick();
    i_valid = 1'b0;
    chk("t5_accept_ready", 32'(o_ready), 32'd0);
    wait_valid("t5b", lat);
    chk("t5b_latency", 32'(lat),      32'd4);
    chk("t5b_equal",   32'(br_equal), 32'd1);
    chk("t5b_less",    32'(br_less),  32'd0);
    chk("t5b_taken",   32'(br_taken), 32'd0);
    tick();

    // Reset during the second CMP cycle aborts the request
    drive(32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0, 3'b000);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_valid", 32'(o_valid),  32'd0);
    chk("t6_ready", 32'(o_ready),  32'd1);
    chk("t6_equal", 32'(br_equal), 32'd0);
    for (int k = 0; k < 6; k++) begin
      chk("t6_no_stale", 32'(o_valid), 32'd0);
      tick();
    end
    run_req("t6_after", 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 3'b100,
            1'b1, 1'b0, 1'b1, EARLY ? 1 : 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
